// File: rtl/jtag_tap_driver_if.sv
// Command/response handshake between a JTAG scan requester (master) and
// the jtag_tap_driver (slave).
interface jtag_tap_driver_if #(
  parameter int unsigned MAX_BITS = 64
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [6:0]          cmd_len;
  logic [MAX_BITS-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAX_BITS-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks the target TAP from Run-Test/Idle through reset, IR/DR
// scans or idle TCK cycles, one command at a time, returning captured TDO bits.
module jtag_tap_driver #(
  parameter int unsigned TCK_HALF = 4,
  parameter int unsigned MAX_BITS = 64
) (
  input  logic             clock,
  input  logic             reset,
  jtag_tap_driver_if.slave bus,
  output logic             jtag_TCK,
  output logic             jtag_TMS,
  output logic             jtag_TDI,
  input  logic             jtag_TDO
);

  localparam int unsigned     HC_W    = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_HALF - 1);
  localparam logic [6:0]      LEN_MAX = 7'(MAX_BITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;
  typedef enum logic [1:0] {P_PRE, P_SHIFT, P_POST} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [3:0]          step_q, step_d;
  logic [6:0]          bit_q, bit_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [MAX_BITS-1:0] rsp_q, rsp_d, data_q, data_d;
  logic [5:0]          pre_tms_q, pre_tms_d;
  logic [3:0]          pre_len_q, pre_len_d;
  logic [6:0]          n_q, n_d;
  logic                scan_q, scan_d, post_q, post_d;

  logic [6:0]          len_c;
  logic [5:0]          dec_pre_tms, cur_pre_tms;
  logic [3:0]          dec_pre_len, cur_pre_len;
  logic [6:0]          dec_n, cur_n;
  logic                dec_scan, dec_post, cur_scan, cur_post;
  logic [MAX_BITS-1:0] cur_data;
  phase_e              sk_phase;
  logic [3:0]          sk_step;
  logic [6:0]          sk_bit;
  logic                sk_done, sk_tms, sk_tdi;
  logic                accept, tck_edge, tck_rise, tck_fall;

  // Command shape: a TMS prefix, N shift/idle cycles, then an optional 1,0 tail.
  always_comb begin : decode
    len_c       = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
    dec_pre_tms = '0;
    dec_pre_len = '0;
    dec_n       = len_c;
    dec_scan    = 1'b0;
    dec_post    = 1'b0;
    case (bus.cmd_op)
      2'd0: begin
        dec_pre_tms = 6'b011111;
        dec_pre_len = 4'd6;
        dec_n       = '0;
      end
      2'd1: begin
        dec_pre_tms = (len_c != '0) ? 6'b000011 : 6'b001011;
        dec_pre_len = 4'd4;
        dec_scan    = 1'b1;
        dec_post    = 1'b1;
      end
      2'd2: begin
        dec_pre_tms = (len_c != '0) ? 6'b000001 : 6'b000101;
        dec_pre_len = 4'd3;
        dec_scan    = 1'b1;
        dec_post    = 1'b1;
      end
      default: ;
    endcase
  end

  // At accept the fresh command is used directly; afterwards its registered copy.
  always_comb begin : cur_cfg
    if (state_q == S_IDLE) begin
      cur_pre_tms = dec_pre_tms;
      cur_pre_len = dec_pre_len;
      cur_n       = dec_n;
      cur_scan    = dec_scan;
      cur_post    = dec_post;
      cur_data    = bus.cmd_data;
    end else begin
      cur_pre_tms = pre_tms_q;
      cur_pre_len = pre_len_q;
      cur_n       = n_q;
      cur_scan    = scan_q;
      cur_post    = post_q;
      cur_data    = data_q;
    end
  end

  // Next TCK cycle position, skipping empty phases, and its TMS/TDI values.
  always_comb begin : seek
    sk_phase = phase_q;
    sk_step  = step_q;
    sk_bit   = bit_q;
    sk_done  = 1'b0;
    if (state_q == S_IDLE) begin
      sk_phase = P_PRE;
      sk_step  = '0;
      sk_bit   = '0;
    end else if (phase_q == P_SHIFT) begin
      sk_bit = 7'(bit_q + 7'd1);
    end else begin
      sk_step = 4'(step_q + 4'd1);
    end
    if (sk_phase == P_PRE && sk_step >= cur_pre_len) begin
      sk_phase = P_SHIFT;
      sk_bit   = '0;
    end
    if (sk_phase == P_SHIFT && sk_bit >= cur_n) begin
      sk_phase = P_POST;
      sk_step  = '0;
    end
    if (sk_phase == P_POST && (!cur_post || sk_step >= 4'd2)) sk_done = 1'b1;
    case (sk_phase)
      P_PRE:   sk_tms = |(cur_pre_tms & (6'd1 << sk_step));
      P_SHIFT: sk_tms = cur_scan && (sk_bit == 7'(cur_n - 7'd1));
      default: sk_tms = (sk_step == 4'd0);
    endcase
    sk_tdi = (sk_phase == P_SHIFT) && cur_scan &&
             (|(cur_data & (MAX_BITS'(1) << sk_bit)));
  end

  assign accept   = (state_q == S_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign tck_edge = (state_q == S_RUN) && (hc_q == HC_LAST);
  assign tck_rise = tck_edge && !tck_q;
  assign tck_fall = tck_edge && tck_q;

  always_ff @(posedge clock or posedge reset) begin : state_reg
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = sk_done ? S_RESP : S_RUN;
      S_RUN:   if (tck_fall && sk_done) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    phase_d     = phase_q;
    step_d      = step_q;
    bit_d       = bit_q;
    hc_d        = hc_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_d       = rsp_q;
    data_d      = data_q;
    pre_tms_d   = pre_tms_q;
    pre_len_d   = pre_len_q;
    n_d         = n_q;
    scan_d      = scan_q;
    post_d      = post_q;
    if (accept) begin
      pre_tms_d = dec_pre_tms;
      pre_len_d = dec_pre_len;
      n_d       = dec_n;
      scan_d    = dec_scan;
      post_d    = dec_post;
      data_d    = bus.cmd_data;
      rsp_d     = '0;
      hc_d      = '0;
      phase_d   = sk_phase;
      step_d    = sk_step;
      bit_d     = sk_bit;
      if (!sk_done) begin
        tms_d = sk_tms;
        tdi_d = sk_tdi;
      end
    end
    if (state_q == S_RUN) begin
      hc_d = tck_edge ? '0 : HC_W'(hc_q + 1'b1);
      if (tck_rise) begin
        tck_d = 1'b1;
        if (phase_q == P_SHIFT && scan_q)
          rsp_d = rsp_q | (MAX_BITS'(jtag_TDO) << bit_q);
      end
      // Falling edge closes the TCK cycle and sets up the next one.
      if (tck_fall) begin
        tck_d   = 1'b0;
        phase_d = sk_phase;
        step_d  = sk_step;
        bit_d   = sk_bit;
        tdi_d   = 1'b0;
        if (!sk_done) begin
          tms_d = sk_tms;
          tdi_d = sk_tdi;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin : regs
    if (reset) begin
      phase_q     <= P_PRE;
      step_q      <= '0;
      bit_q       <= '0;
      hc_q        <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      data_q      <= '0;
      pre_tms_q   <= '0;
      pre_len_q   <= '0;
      n_q         <= '0;
      scan_q      <= 1'b0;
      post_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      step_q      <= step_d;
      bit_q       <= bit_d;
      hc_q        <= hc_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      data_q      <= data_d;
      pre_tms_q   <= pre_tms_d;
      pre_len_q   <= pre_len_d;
      n_q         <= n_d;
      scan_q      <= scan_d;
      post_q      <= post_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q;
  assign jtag_TCK      = tck_q;
  assign jtag_TMS      = tms_q;
  assign jtag_TDI      = tdi_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver against a small IEEE 1149.1 TAP model
// holding a 5-bit IR (capture 0b00001) and a 32-bit IDCODE register.
module tb_jtag_tap_driver;
  localparam int unsigned TCK_HALF = 2;
  localparam int unsigned MAX_BITS = 64;
  localparam logic [31:0] IDCODE   = 32'h2000_0913;

  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_e;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic jtag_TCK, jtag_TMS, jtag_TDI;
  logic jtag_TDO = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  jtag_tap_driver_if #(.MAX_BITS(MAX_BITS)) bif ();

  jtag_tap_driver #(.TCK_HALF(TCK_HALF), .MAX_BITS(MAX_BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bif.slave),
    .jtag_TCK (jtag_TCK),
    .jtag_TMS (jtag_TMS),
    .jtag_TDI (jtag_TDI),
    .jtag_TDO (jtag_TDO)
  );

  always #5 clock = ~clock;

  // Target TAP model
  tap_e        tap   = TLR;
  logic [4:0]  ir    = 5'h01;
  logic [4:0]  ir_sr = 5'h00;
  logic [31:0] dr_sr = 32'h0;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PA_DR;
      PA_DR:   return tms ? EX2_DR : PA_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PA_IR;
      PA_IR:   return tms ? EX2_IR : PA_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge jtag_TCK) begin
    case (tap)
      TLR:     ir    <= 5'h01;
      CAP_IR:  ir_sr <= 5'b00001;
      SH_IR:   ir_sr <= {jtag_TDI, ir_sr[4:1]};
      UPD_IR:  ir    <= ir_sr;
      CAP_DR:  dr_sr <= (ir == 5'h01) ? IDCODE : 32'h0;
      SH_DR:   dr_sr <= {jtag_TDI, dr_sr[31:1]};
      default: ;
    endcase
    tap <= tap_next(tap, jtag_TMS);
  end

  always @(negedge jtag_TCK)
    jtag_TDO <= (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;

  // Pin monitor: logs TMS/TDI per TCK cycle plus period and high width in clocks
  logic tms_log [0:511];
  logic tdi_log [0:511];
  int   per_log [0:511];
  int   hi_log  [0:511];
  int   rises     = 0;
  int   cyc       = 0;
  int   last_rise = 0;
  logic tck_prev  = 1'b0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    tck_prev <= jtag_TCK;
    if (jtag_TCK && !tck_prev) begin
      tms_log[rises] <= jtag_TMS;
      tdi_log[rises] <= jtag_TDI;
      per_log[rises] <= cyc - last_rise;
      last_rise      <= cyc;
      rises          <= rises + 1;
    end
    if (!jtag_TCK && tck_prev && rises > 0) hi_log[rises-1] <= cyc - last_rise;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] log_vec(input int base, input int n, input bit use_tdi);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (64'(use_tdi ? tdi_log[base+i] : tms_log[base+i]) << i);
    return v;
  endfunction

  function automatic int bad_timing(input int base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && per_log[base+i] != 2 * TCK_HALF) bad++;
      if (hi_log[base+i] != TCK_HALF) bad++;
    end
    return bad;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    bit done;
    done = 1'b0;
    bif.cmd_op    = op;
    bif.cmd_len   = len;
    bif.cmd_data  = data;
    bif.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bif.cmd_ready) done = 1'b1;
      @(negedge clock);
    end
    bif.cmd_valid = 1'b0;
    check("cmd_accept", 64'(done), 64'd1);
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (bif.rsp_valid) got = 1'b1;
      else @(negedge clock);
    end
    check("rsp_arrives", 64'(got), 64'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic finish_rsp();
    check("ready_in_exit", 64'(bif.cmd_ready), 64'd0);
    bif.rsp_ready = 1'b1;
    @(negedge clock);
    bif.rsp_ready = 1'b0;
    check("rsp_dropped", 64'(bif.rsp_valid), 64'd0);
    check("ready_again", 64'(bif.cmd_ready), 64'd1);
  endtask

  int base;
  int hold_bad;

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = '0;
    bif.cmd_len   = '0;
    bif.cmd_data  = '0;
    bif.rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 64'(bif.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
    check("rst_rsp_data", bif.rsp_data, 64'd0);
    check("rst_tck", 64'(jtag_TCK), 64'd0);
    check("rst_tms", 64'(jtag_TMS), 64'd1);
    check("rst_tdi", 64'(jtag_TDI), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'(bif.cmd_ready), 64'd1);

    // TAP reset
    base = rises;
    issue(2'd0, 7'd0, 64'd0);
    wait_rsp();
    check("op0_pulses", 64'(rises - base), 64'd6);
    check("op0_tms", log_vec(base, 6, 1'b0), 64'h1F);
    check("op0_timing", 64'(bad_timing(base, 6)), 64'd0);
    check("op0_rsp", bif.rsp_data, 64'd0);
    check("op0_tck_rest", 64'(jtag_TCK), 64'd0);
    check("op0_tap_rti", 64'(tap), 64'(RTI));
    finish_rsp();

    // IR scan selecting IDCODE
    base = rises;
    issue(2'd1, 7'd5, 64'h01);
    wait_rsp();
    check("ir_pulses", 64'(rises - base), 64'd11);
    check("ir_tms", log_vec(base, 11, 1'b0), 64'h303);
    check("ir_tdi", log_vec(base, 11, 1'b1), 64'h010);
    check("ir_rsp", bif.rsp_data, 64'h01);
    check("ir_model_ir", 64'(ir), 64'h01);
    check("ir_tap_rti", 64'(tap), 64'(RTI));
    finish_rsp();

    // 32-bit IDCODE read
    base = rises;
    issue(2'd2, 7'd32, 64'd0);
    wait_rsp();
    check("dr32_pulses", 64'(rises - base), 64'd37);
    check("dr32_tms", log_vec(base, 37, 1'b0), 64'h0C_0000_0001);
    check("dr32_timing", 64'(bad_timing(base, 37)), 64'd0);
    check("dr32_rsp", bif.rsp_data, 64'h2000_0913);
    finish_rsp();

    // Over-long scan clamps to MAX_BITS
    base = rises;
    issue(2'd2, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_rsp();
    check("dr100_pulses", 64'(rises - base), 64'd69);
    check("dr100_rsp", bif.rsp_data, 64'hFFFF_FFFF_2000_0913);
    check("dr100_tap_rti", 64'(tap), 64'(RTI));
    finish_rsp();

    // Zero idle cycles respond immediately
    base = rises;
    issue(2'd3, 7'd0, 64'd0);
    check("idle0_rsp_next", 64'(bif.rsp_valid), 64'd1);
    repeat (2) @(negedge clock);
    check("idle0_pulses", 64'(rises - base), 64'd0);
    check("idle0_rsp", bif.rsp_data, 64'd0);
    finish_rsp();

    // Three idle cycles with a stalled response
    base = rises;
    issue(2'd3, 7'd3, 64'hFFFF);
    wait_rsp();
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== 64'd0 || bif.cmd_ready !== 1'b0) hold_bad++;
      @(negedge clock);
    end
    check("idle3_hold", 64'(hold_bad), 64'd0);
    check("idle3_pulses", 64'(rises - base), 64'd3);
    check("idle3_tms", log_vec(base, 3, 1'b0), 64'd0);
    check("idle3_tdi", log_vec(base, 3, 1'b1), 64'd0);
    finish_rsp();

    // Reset during shift cycle 10 of a DR scan
    base = rises;
    issue(2'd2, 7'd32, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 500 && (rises - base) < 14; i++) @(negedge clock);
    check("abort_reached", 64'(rises - base), 64'd14);
    check("abort_pre_tck", 64'(jtag_TCK), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_tck", 64'(jtag_TCK), 64'd0);
    check("abort_tms", 64'(jtag_TMS), 64'd1);
    check("abort_tdi", 64'(jtag_TDI), 64'd0);
    check("abort_rsp_valid", 64'(bif.rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(bif.cmd_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(2'd0, 7'd0, 64'd0);
    wait_rsp();
    check("recover_tap_rti", 64'(tap), 64'(RTI));
    finish_rsp();
    issue(2'd2, 7'd32, 64'd0);
    wait_rsp();
    check("recover_idcode", bif.rsp_data, 64'h2000_0913);
    finish_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
- Synthesizable JTAG initiator that drives jtag_TCK/TMS/TDI and samples jtag_TDO of the rocketchip_wrapper debug TAP.
- Lets Verilator benches and FPGA self-test logic issue IR/DR scans from a simple command/response handshake instead of an external JTAG cable/VPI.
- Walks the IEEE 1149.1 TAP state machine itself. The target TAP rests in Run-Test/Idle between commands.

Parameters:
- TCK_HALF, 4, clock cycles per TCK half-period (>=1); TCK period = 2*TCK_HALF clocks.
- MAX_BITS, 64, maximum scan length and width of cmd_data/rsp_data.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  driver accepts command (valid&ready = accept).
- cmd_op  input  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=idle TCK cycles.
- cmd_len  input  7  scan length in bits, or idle cycle count; values >MAX_BITS clamp to MAX_BITS.
- cmd_data  input  MAX_BITS  TDI bits, LSB shifted first.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed (valid&ready).
- rsp_data  output  MAX_BITS  captured TDO bits, bit i = i-th shifted bit, unused upper bits 0.
- jtag_TCK  output  1  test clock.
- jtag_TMS  output  1  test mode select.
- jtag_TDI  output  1  test data in.
- jtag_TDO  input  1  test data out from target.

Behaviour:
- Reset values:
  - cmd_ready=0 while reset asserted, 1 in the first cycle after release.
  - rsp_valid=0, rsp_data=0, jtag_TCK=0, jtag_TMS=1, jtag_TDI=0.
  - Internal state IDLE.
- States:
  - IDLE: cmd_ready=1 only here and only when rsp_valid=0.
  - RUN: performs the TMS/TDI sequence.
  - RESP: rsp_valid=1 until rsp_ready.
  - Transitions: IDLE -> RUN on accept; RUN -> RESP after the last TCK falling edge; RESP -> IDLE on rsp_valid & rsp_ready.
  - cmd_ready is not asserted in the RESP exit cycle.
- TCK generation:
  - Each TCK cycle is TCK_HALF clocks low followed by TCK_HALF clocks high; a half-period counter wraps at TCK_HALF-1.
  - TMS/TDI update at the clock edge that drives TCK low (the start of each TCK cycle) and hold stable for the full TCK cycle.
  - jtag_TDO is sampled on the clock edge that drives TCK high.
  - The command finishes after the last falling edge; TCK rests at 0 in IDLE/RESP.
- TMS sequences (one entry per TCK cycle):
  - op0 TAP reset: 1,1,1,1,1,0. Ends in Run-Test/Idle; rsp_data=0.
  - op1 IR scan, len N>=1: 1,1,0,0, then N shift cycles with TMS=0 except the last with TMS=1, then 1,0.
    - Total TCK cycles = N+6.
    - TDI = cmd_data[i] during shift cycle i; TDI=0 outside shift cycles.
  - op2 DR scan: same as IR scan without the second leading 1 (1,0,0, shift, 1,0). Total TCK cycles = N+5.
  - N=0 scans skip Shift: IR 1,1,0,1,1,0; DR 1,0,1,1,0. rsp_data=0.
  - op3 idle: N cycles with TMS=0. N=0 gives zero TCK cycles and a response on the next cycle; rsp_data=0.
- TDO capture:
  - TDO is sampled only on rising edges of shift cycles.
  - Sample i is written to rsp_data[i]; a MAX_BITS shift register plus a bit counter.
  - rsp_data is cleared on command accept and held stable while rsp_valid=1.
- Counters: a 7-bit bit counter and a 4-bit sequence-step counter; no overflow beyond MAX_BITS thanks to the clamp.
- Back-to-back: the next command is accepted at the earliest one cycle after the RESP handshake; TMS holds its last value (0) in between.
- Reset mid-command: outputs return to reset values immediately (asynchronous).
  - Any pending response is discarded.
  - The target TAP state is then unknown; issuing op0 is the caller's responsibility.
- cmd_* inputs are ignored outside IDLE; cmd_data/len/op are registered at accept.

Test Plan:
- Reset, then op0 with TCK_HALF=2 -> exactly 6 TCK pulses, each 4 clocks; TMS per cycle 1,1,1,1,1,0; rsp_data=0; cmd_ready=1 again after rsp handshake.
- op1 len=5 data=0x01 against TAP model (IR capture 0b00001) -> 11 TCK cycles; TDI shift bits 1,0,0,0,0; rsp_data=0x01; model ends in Run-Test/Idle with IR=0x01.
- op2 len=32 against IDCODE model 0x20000913 -> 37 TCK cycles; rsp_data=0x20000913; TMS=1 only on Select-DR, last shift, and Update cycles.
- op2 len=100 data=all ones -> clamped to 64 shift cycles; rsp_data[63:0] equals model's 64 captured bits; no counter wrap.
- op3 len=0, then op3 len=3 with rsp_ready held low 10 cycles -> first response next cycle with zero TCK pulses; second: 3 pulses with TMS=0, rsp_valid stays 1 and rsp_data stable until rsp_ready, cmd_ready=0 throughout.
- Assert reset during shift cycle 10 of a 32-bit DR scan -> same cycle TCK=0, TMS=1, TDI=0, rsp_valid=0; after release op0 then IDCODE scan returns 0x20000913.
